// File: rtl/fir_coeff_loader.sv
// Streams NUM_TAPS coefficients into the FIR coefficient RAM as write cycles.
// Define FIR_COEFF_READBACK_EN to add a readback pass with a checksum compare.
module fir_coeff_loader #(
  parameter int NUM_TAPS  = 33,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 16,
  parameter int ADDR_BASE = 1,
  parameter int RD_LAT    = 1
) (
  input  logic              iClk_12M,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeffData,
  output logic              oCoeffReady,
  output logic              oCoeffiUpdateFlag,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWrDtRam,
  input  logic [DATA_W-1:0] iRdDtRam,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);
  localparam int K_W = $clog2(NUM_TAPS + 1);

  if (ADDR_BASE + NUM_TAPS - 1 > (1 << ADDR_W) - 1) begin : g_addr_range_chk
    $error("fir_coeff_loader: coefficient address range exceeds RAM");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_rd_lat_chk
    $error("fir_coeff_loader: RD_LAT must be 1..3");
  end

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              ready_q, ready_d;
  logic              flag_q, flag_d;
  logic              csn_q, csn_d;
  logic              wrn_q, wrn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hs;

`ifdef FIR_COEFF_READBACK_EN
  logic [DATA_W-1:0] wsum_q, wsum_d;
  logic [DATA_W-1:0] rsum_q, rsum_d;
  logic [DATA_W-1:0] smp_q, smp_d;
  logic              smp_vld_q, smp_vld_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [1:0]        drain_q, drain_d;
`else
  logic unused_rd;
  assign unused_rd = ^iRdDtRam;
`endif

  assign hs = (state_q == WRITE) && ready_q && iCoeffValid;

  // NOTE: every _d gets a default first, so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ready_d = ready_q;
    flag_d  = flag_q;
    csn_d   = csn_q;
    wrn_d   = wrn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef FIR_COEFF_READBACK_EN
    wsum_d    = wsum_q;
    drain_d   = drain_q;
    // Read data is registered once before it joins the checksum.
    pipe_d    = (pipe_q << 1) | RD_LAT'(state_q == READ);
    smp_d     = iRdDtRam;
    smp_vld_d = pipe_q[RD_LAT-1];
    rsum_d    = smp_vld_q ? rsum_q + smp_q : rsum_q;
`endif

    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = WRITE;
          k_d     = '0;
          ready_d = 1'b1;
          flag_d  = 1'b1;
          err_d   = 1'b0;
`ifdef FIR_COEFF_READBACK_EN
          wsum_d  = '0;
          rsum_d  = '0;
`endif
        end
      end
      WRITE: begin
        csn_d = 1'b1;
        wrn_d = 1'b1;
        if (hs) begin
          csn_d   = 1'b0;
          wrn_d   = 1'b0;
          addr_d  = ADDR_W'(ADDR_BASE) + ADDR_W'(k_q);
          wdata_d = iCoeffData;
          k_d     = k_q + 1'b1;
          ready_d = (k_q != K_W'(NUM_TAPS - 1));
`ifdef FIR_COEFF_READBACK_EN
          wsum_d  = wsum_q + iCoeffData;
`endif
        end else if (k_q == K_W'(NUM_TAPS)) begin
          flag_d  = 1'b0;
`ifdef FIR_COEFF_READBACK_EN
          state_d = READ;
          csn_d   = 1'b0;
          addr_d  = ADDR_W'(ADDR_BASE);
          k_d     = '0;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef FIR_COEFF_READBACK_EN
      READ: begin
        if (k_q == K_W'(NUM_TAPS - 1)) begin
          state_d = DRAIN;
          csn_d   = 1'b1;
          drain_d = 2'(RD_LAT);
        end else begin
          k_d    = k_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd0) state_d = DONE;
        else                 drain_d = drain_q - 2'd1;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
`ifdef FIR_COEFF_READBACK_EN
    if (state_d == DONE) err_d = (rsum_d != wsum_q);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      ready_q   <= 1'b0;
      flag_q    <= 1'b0;
      csn_q     <= 1'b1;
      wrn_q     <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef FIR_COEFF_READBACK_EN
      wsum_q    <= '0;
      rsum_q    <= '0;
      smp_q     <= '0;
      smp_vld_q <= 1'b0;
      pipe_q    <= '0;
      drain_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      ready_q   <= ready_d;
      flag_q    <= flag_d;
      csn_q     <= csn_d;
      wrn_q     <= wrn_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef FIR_COEFF_READBACK_EN
      wsum_q    <= wsum_d;
      rsum_q    <= rsum_d;
      smp_q     <= smp_d;
      smp_vld_q <= smp_vld_d;
      pipe_q    <= pipe_d;
      drain_q   <= drain_d;
`endif
    end
  end

  assign oCoeffReady       = ready_q;
  assign oCoeffiUpdateFlag = flag_q;
  assign oCsnRam           = csn_q;
  assign oWrnRam           = wrn_q;
  assign oAddrRam          = addr_q;
  assign oWrDtRam          = wdata_q;
  assign oBusy             = busy_q;
  assign oDone             = done_q;
  assign oErr              = err_q;

endmodule
